// File: rtl/i2c_eeprom_target_pkg.sv
// Shared definitions for the I2C EEPROM-style target: FSM states,
// control-byte constants and the default target address.
package i2c_eeprom_target_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;
  localparam logic [7:0] CTRL_WR          = 8'hA0;
  localparam logic [7:0] CTRL_RD          = 8'hA1;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    WADDR,
    ACK_WADDR,
    WDATA,
    ACK_WDATA,
    RDATA,
    RACK,
    WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_eeprom_target_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, with rise/fall
// detection on the synchronized copy. Flops preset to 1 (idle bus level).
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target exposing a small byte array with an auto-incrementing word
// pointer; supports byte/page writes, current-address and random reads.
module i2c_eeprom_target
  import i2c_eeprom_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SCL,
  input  logic                     SDA_IN,
  output logic                     SDA_OE,
  output logic [$clog2(DEPTH)-1:0] WORD_PTR,
  output logic                     WR_STB,
  output logic                     BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge u_scl_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .d_i     (SCL),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .d_i     (SDA_IN),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          oe_q, oe_d;
  logic          wr_stb_q, wr_stb_d;
  logic          mem_we;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_rd;

  assign mem_rd  = mem_q[ptr_q];
  assign ptr_inc = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[ptr_q] <= shift_d;
  end

  // In ACK states bit_cnt marks whether the 9th-clock drive has begun;
  // in RACK it records that the initiator acknowledged.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    mem_we    = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      oe_d      = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        DEVADDR, WADDR, WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == DEVADDR) begin
                state_d = (shift_d[7:1] == DEV_ADDR) ? ACK_DEV : WAIT_STOP;
              end else if (state_q == WADDR) begin
                ptr_d   = shift_d[AW-1:0];
                state_d = ACK_WADDR;
              end else begin
                mem_we   = 1'b1;
                wr_stb_d = 1'b1;
                ptr_d    = ptr_inc;
                state_d  = ACK_WDATA;
              end
            end
          end
        end

        ACK_DEV, ACK_WADDR, ACK_WDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_d      = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ACK_DEV && shift_q[0]) begin
                shift_d = mem_rd;
                oe_d    = ~mem_rd[7];
                state_d = RDATA;
              end else if (state_q == ACK_DEV) begin
                state_d = WADDR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              ptr_d     = ptr_inc;
              bit_cnt_d = '0;
              state_d   = RACK;
            end else begin
              oe_d    = ~shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end

        RACK: begin
          if (scl_rise) begin
            if (!sda_lvl) bit_cnt_d = 4'd1;
            else          state_d   = WAIT_STOP;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            shift_d   = mem_rd;
            oe_d      = ~mem_rd[7];
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end

        default: ;
      endcase
    end
  end

  assign SDA_OE   = oe_q;
  assign WORD_PTR = ptr_q;
  assign WR_STB   = wr_stb_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: drives an I2C initiator on a
// wired-AND SDA line and checks ACKs, read data, pointer and strobes.
module tb_i2c_eeprom_target;
  import i2c_eeprom_target_pkg::*;

  localparam int unsigned Q = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       SDA_OE;
  logic [3:0] WORD_PTR;
  logic       WR_STB;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  assign sda_line = sda_m & ~SDA_OE;

  i2c_eeprom_target #(
    .DEV_ADDR (7'h50),
    .DEPTH    (16)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SCL      (scl),
    .SDA_IN   (sda_line),
    .SDA_OE   (SDA_OE),
    .WORD_PTR (WORD_PTR),
    .WR_STB   (WR_STB),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (WR_STB) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    sda_m = 1'b0; wait_q(Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    sda_m = 1'b1; wait_q(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q(Q);
    scl   = 1'b1; wait_q(2 * Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    b     = sda_line; wait_q(Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  // Sends a byte plus the ACK clock; lat=1 also checks the 3-CLK SDA_OE delay.
  task automatic write_byte(input logic [7:0] b, input logic lat, output logic ack);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    sda_m = b[0]; wait_q(Q);
    scl   = 1'b1; wait_q(2 * Q);
    scl   = 1'b0;
    if (lat) begin
      wait_q(2);
      check("ack_lat_2clk", SDA_OE, 1'b0);
      wait_q(1);
      check("ack_lat_3clk", SDA_OE, 1'b1);
      wait_q(Q - 3);
    end else begin
      wait_q(Q);
    end
    sda_m = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    ack   = ~sda_line; wait_q(Q);
    scl   = 1'b0; wait_q(Q);
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(~give_ack);
  endtask

  logic       ack;
  logic [7:0] rd;
  logic       bit_v;
  int         wr_base;

  initial begin
    RESET = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wait_q(3);
    check("rst_oe",   SDA_OE,   1'b0);
    check("rst_ptr",  WORD_PTR, 4'd0);
    check("rst_wstb", WR_STB,   1'b0);
    check("rst_busy", BUSY,     1'b0);
    RESET = 1'b0;
    wait_q(Q);

    // Single byte write to address 3
    i2c_start();
    check("t1_busy", BUSY, 1'b1);
    write_byte(CTRL_WR, 1'b1, ack); check("t1_ack_ctrl", ack, 1'b1);
    write_byte(8'h03,   1'b0, ack); check("t1_ack_addr", ack, 1'b1);
    write_byte(8'h5A,   1'b0, ack); check("t1_ack_data", ack, 1'b1);
    i2c_stop();
    check("t1_ptr",    WORD_PTR, 4'd4);
    check("t1_wr_cnt", wr_cnt,   1);
    check("t1_idle",   BUSY,     1'b0);

    // Random read of address 3 via repeated START
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack); check("t2_ack_ctrl", ack, 1'b1);
    write_byte(8'h03,   1'b0, ack); check("t2_ack_addr", ack, 1'b1);
    check("t2_ptr_set", WORD_PTR, 4'd3);
    i2c_start();
    write_byte(CTRL_RD, 1'b0, ack); check("t2_ack_rd", ack, 1'b1);
    read_byte(1'b0, rd);
    check("t2_rdata", rd, 8'h5A);
    i2c_stop();
    check("t2_ptr",  WORD_PTR, 4'd4);
    check("t2_idle", BUSY,     1'b0);
    check("t2_oe",   SDA_OE,   1'b0);

    // Two-byte write across the pointer wrap, then read both back
    wr_base = wr_cnt;
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h0F,   1'b0, ack); check("t3_ack_addr", ack, 1'b1);
    write_byte(8'h11,   1'b0, ack); check("t3_ack_d0", ack, 1'b1);
    write_byte(8'h22,   1'b0, ack); check("t3_ack_d1", ack, 1'b1);
    i2c_stop();
    check("t3_ptr_wrap", WORD_PTR, 4'd1);
    check("t3_wr_cnt",   wr_cnt - wr_base, 2);
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h0F,   1'b0, ack);
    i2c_start();
    write_byte(CTRL_RD, 1'b0, ack);
    read_byte(1'b1, rd); check("t3_rd_mem15", rd, 8'h11);
    read_byte(1'b0, rd); check("t3_rd_mem0",  rd, 8'h22);
    i2c_stop();
    check("t3_ptr_after_rd", WORD_PTR, 4'd1);

    // Foreign control byte: no ACK, bus ignored until STOP
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'hA4, 1'b0, ack); check("t4_nack_ctrl", ack, 1'b0);
    check("t4_busy", BUSY, 1'b1);
    write_byte(8'h00, 1'b0, ack); check("t4_nack_next", ack, 1'b0);
    check("t4_ptr",    WORD_PTR, 4'd1);
    check("t4_wr_cnt", wr_cnt - wr_base, 0);
    i2c_stop();
    check("t4_idle", BUSY, 1'b0);
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h03,   1'b0, ack);
    i2c_start();
    write_byte(CTRL_RD, 1'b0, ack);
    read_byte(1'b0, rd); check("t4_mem3_kept", rd, 8'h5A);
    i2c_stop();

    // Reset in the middle of a read while the target holds SDA low
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h02,   1'b0, ack);
    write_byte(8'h44,   1'b0, ack); check("t5_ack_wr", ack, 1'b1);
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h02,   1'b0, ack);
    i2c_start();
    write_byte(CTRL_RD, 1'b0, ack);
    check("t5_ptr_pre", WORD_PTR, 4'd2);
    for (int i = 0; i < 3; i++) read_bit(bit_v);
    sda_m = 1'b1; wait_q(Q);
    scl   = 1'b1; wait_q(Q);
    check("t5_oe_bit3", SDA_OE, 1'b1);
    RESET = 1'b1;
    wait_q(1);
    check("t5_rst_oe",   SDA_OE,   1'b0);
    check("t5_rst_ptr",  WORD_PTR, 4'd0);
    check("t5_rst_busy", BUSY,     1'b0);
    RESET = 1'b0;
    wait_q(2 * Q);
    check("t5_stay_idle", BUSY, 1'b0);
    i2c_start();
    write_byte(CTRL_RD, 1'b0, ack); check("t5_ack_rd", ack, 1'b1);
    read_byte(1'b0, rd); check("t5_rdata", rd, 8'h22);
    i2c_stop();
    check("t5_ptr_post", WORD_PTR, 4'd1);

    // START after 5 bits of a data byte discards it
    wr_base = wr_cnt;
    i2c_start();
    write_byte(CTRL_WR, 1'b0, ack);
    write_byte(8'h05,   1'b0, ack); check("t6_ack_addr", ack, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    check("t6_wr_cnt", wr_cnt - wr_base, 0);
    check("t6_ptr",    WORD_PTR, 4'd5);
    write_byte(CTRL_WR, 1'b0, ack); check("t6_ack_new", ack, 1'b1);
    i2c_stop();
    check("t6_ptr_end", WORD_PTR, 4'd5);
    check("t6_idle",    BUSY,     1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_target.md
I2C_EEPROM_TARGET -- requirements
Module: i2c_eeprom_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50: 7-bit target address. Control byte 8'hA0 selects write; 8'hA1 selects read.
REQ-002 Parameter DEPTH, default 16: number of bytes in the array. Word address width is 4.
REQ-003 CLK  in  1  single system clock; all logic is on its rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 SCL  in  1  I2C clock from the initiator, asynchronous.
REQ-006 SDA_IN  in  1  sampled I2C data line, asynchronous.
REQ-007 SDA_OE  out  1  1 drives SDA low; 0 releases SDA (open-drain).
REQ-008 WORD_PTR  out  4  current internal address pointer.
REQ-009 WR_STB  out  1  one-CLK pulse on each array write.
REQ-010 BUSY  out  1  high from START until STOP or return to IDLE.

Function
REQ-011 SCL and SDA_IN SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized copies.
REQ-012 START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high.
REQ-013 Data is sampled on SCL rising edges, MSB first. SDA_OE changes only on synchronized SCL falling edges; update latency is exactly 3 CLK after the SCL pin falls.
REQ-014 States: IDLE, DEVADDR, ACK_DEV, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, RACK, WAIT_STOP.
REQ-015 START in any state SHALL clear the bit counter and go to DEVADDR; repeated START is treated identically.
REQ-016 STOP in any state SHALL go to IDLE and release SDA_OE the same cycle.
REQ-017 DEVADDR, after 8 bits:
- byte[7:1]==DEV_ADDR: go to ACK_DEV and drive SDA low for the 9th clock.
- otherwise: go to WAIT_STOP with no ACK.
REQ-018 After ACK_DEV:
- R/W=0: go to WADDR.
- R/W=1: go to RDATA and load the shift register with mem[WORD_PTR].
REQ-019 WADDR: the received byte's bits [3:0] load WORD_PTR; bits [7:4] are ignored. Then ACK and go to WDATA.
REQ-020 WDATA: on the 8th sampled bit, write mem[WORD_PTR] with WR_STB high for 1 CLK, increment WORD_PTR, then ACK and return to WDATA.
REQ-021 RDATA: drive the bit onto SDA_OE (bit 0 means OE=1). After 8 bits, increment WORD_PTR, release SDA and go to RACK.
REQ-022 RACK: initiator ACK (SDA low) SHALL reload mem[WORD_PTR] and go to RDATA; NACK SHALL go to WAIT_STOP.
REQ-023 WORD_PTR SHALL wrap 15->0, modulo DEPTH.
REQ-024 A START arriving mid-byte SHALL discard the partial byte; no write and no pointer change.
REQ-025 WAIT_STOP SHALL ignore SCL and leave SDA released until START or STOP.

Reset
REQ-026 On RESET:
- state=IDLE, SDA_OE=0, WORD_PTR=0, WR_STB=0, BUSY=0.
- synchronizers preset to 1 (bus idle high).
- array contents are not cleared.
REQ-027 RESET asserted mid-transfer SHALL release SDA the next cycle; the target stays in IDLE until a fresh START.

Structure
REQ-028 A shared package SHALL hold the state enum, the 8'hA0/8'hA1 control constants and DEV_ADDR default.
REQ-029 The 2-flop synchronizer with edge detect SHALL be one sub-module, i2c_sync_edge, instantiated for SCL and SDA.

Verification
REQ-030 Write A0, 03, 5A, STOP -> ACK on all 3 bytes; mem[3]=8'h5A; WORD_PTR=4; one WR_STB pulse.
REQ-031 Write A0, 03; repeated START; A1; read 1 byte with NACK; STOP -> returns 8'h5A; WORD_PTR=4; state IDLE.
REQ-032 Write A0, 0F, 11, 22 -> mem[15]=8'h11, mem[0]=8'h22; WORD_PTR=1 (wrap).
REQ-033 Control byte A4 -> no ACK (SDA released on 9th clock); no state change until STOP; mem unchanged.
REQ-034 RESET asserted during RDATA bit 3 while SDA_OE=1 -> SDA_OE=0 next CLK; WORD_PTR=0; the next A1 read ACKs normally.
REQ-035 START after 5 bits of a WDATA byte -> no WR_STB; WORD_PTR unchanged; a new DEVADDR is accepted.
